// File: rtl/tick_generator_param.sv
// -----------------------------------------------------------------------------
// tick_generator_param
// Run-time programmable clock-enable generator. A down-counter divides clock_in
// by the active divisor and emits a one-cycle tick_out on every wrap. A cascaded
// sub counter emits sub_tick_out together with every SUB_DIV-th tick. A new
// divisor is staged in a shadow register and becomes active at the next wrap
// or at a sync_clear. No derived clocks leave this block.
//
// Optional feature macro: TICK_SQUARE_OUT_EN
//   defined   -> square_out toggles on every wrap (period 2*divisor)
//   undefined -> square_out tied to 0
//
// Ports
//   clock_in      in   1      system clock, all flops on posedge
//   reset         in   1      asynchronous, active-high reset
//   enable        in   1      1 = count; 0 = freeze counters, strobes low
//   sync_clear    in   1      synchronous restart of the period
//   div_load      in   1      capture div_value into the shadow register
//   div_value     in   CNT_W  new divisor (must be >= 2)
//   load_ack      out  1      pulse: shadow divisor became active
//   load_err      out  1      pulse: div_load rejected (div_value < 2)
//   tick_out      out  1      pulse, period = active divisor (enabled cycles)
//   sub_tick_out  out  1      pulse with every SUB_DIV-th tick_out
//   count_out     out  CNT_W  current down-counter value
//   square_out    out  1      50% duty square wave (optional)
// -----------------------------------------------------------------------------
module tick_generator_param #(
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    parameter int unsigned SUB_DIV     = 10,
    parameter int unsigned SUB_W       = 4
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clear,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             load_ack,
    output logic             load_err,
    output logic             tick_out,
    output logic             sub_tick_out,
    output logic [CNT_W-1:0] count_out,
    output logic             square_out
);

    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_CNT  = CNT_W'(DEFAULT_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);

    // State registers
    logic [CNT_W-1:0] count_q,      count_d;
    logic [SUB_W-1:0] sub_cnt_q,    sub_cnt_d;
    logic [CNT_W-1:0] active_div_q, active_div_d;
    logic [CNT_W-1:0] pend_div_q,   pend_div_d;
    logic             pend_valid_q, pend_valid_d;
    logic             tick_q,       tick_d;
    logic             sub_tick_q,   sub_tick_d;
    logic             load_ack_q,   load_ack_d;
    logic             load_err_q,   load_err_d;
`ifdef TICK_SQUARE_OUT_EN
    logic             square_q,     square_d;
`endif

    // Decoded request and the divisor the next period will use
    logic             load_ok_c;
    logic             load_bad_c;
    logic [CNT_W-1:0] div_next_c;
    logic             wrap_c;

    always_comb begin
        load_ok_c  = div_load && (div_value >= MIN_DIV);
        load_bad_c = div_load && (div_value <  MIN_DIV);
        div_next_c = pend_valid_q ? pend_div_q : active_div_q;
        wrap_c     = enable && (count_q == '0);
    end

    // Next-state and registered-output logic
    always_comb begin
        count_d      = count_q;
        sub_cnt_d    = sub_cnt_q;
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        tick_d       = 1'b0;
        sub_tick_d   = 1'b0;
        load_ack_d   = 1'b0;
        load_err_d   = 1'b0;
`ifdef TICK_SQUARE_OUT_EN
        square_d     = square_q;
`endif

        if (sync_clear) begin
            // Restart the period regardless of enable; a valid load in the
            // same cycle bypasses the shadow and is applied directly.
            if (load_ok_c) begin
                active_div_d = div_value;
                count_d      = div_value - CNT_ONE;
                load_ack_d   = 1'b1;
            end else begin
                active_div_d = div_next_c;
                count_d      = div_next_c - CNT_ONE;
                load_ack_d   = pend_valid_q;
            end
            pend_valid_d = 1'b0;
            load_err_d   = load_bad_c;
            sub_cnt_d    = '0;
`ifdef TICK_SQUARE_OUT_EN
            square_d     = 1'b0;
`endif
        end else begin
            if (wrap_c) begin
                // Wrap uses the shadow state as it was before this cycle
                count_d      = div_next_c - CNT_ONE;
                active_div_d = div_next_c;
                tick_d       = 1'b1;
                if (pend_valid_q) begin
                    pend_valid_d = 1'b0;
                    load_ack_d   = 1'b1;
                end
                if (sub_cnt_q == SUB_LAST) begin
                    sub_cnt_d  = '0;
                    sub_tick_d = 1'b1;
                end else begin
                    sub_cnt_d  = sub_cnt_q + SUB_ONE;
                end
`ifdef TICK_SQUARE_OUT_EN
                square_d     = ~square_q;
`endif
            end else if (enable) begin
                count_d = count_q - CNT_ONE;
            end

            // A load is accepted whether or not counting is enabled; a load
            // on the wrap cycle re-arms the shadow for the following wrap.
            if (load_ok_c) begin
                pend_div_d   = div_value;
                pend_valid_d = 1'b1;
            end
            load_err_d = load_bad_c;
        end
    end

    // State register
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            count_q      <= DEF_CNT;
            sub_cnt_q    <= '0;
            active_div_q <= DEF_DIV;
            pend_div_q   <= '0;
            pend_valid_q <= 1'b0;
            tick_q       <= 1'b0;
            sub_tick_q   <= 1'b0;
            load_ack_q   <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            sub_cnt_q    <= sub_cnt_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            tick_q       <= tick_d;
            sub_tick_q   <= sub_tick_d;
            load_ack_q   <= load_ack_d;
            load_err_q   <= load_err_d;
        end
    end

`ifdef TICK_SQUARE_OUT_EN
    // Square-wave register, toggled by every wrap
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            square_q <= 1'b0;
        end else begin
            square_q <= square_d;
        end
    end

    assign square_out = square_q;
`else
    assign square_out = 1'b0;
`endif

    assign count_out    = count_q;
    assign tick_out     = tick_q;
    assign sub_tick_out = sub_tick_q;
    assign load_ack     = load_ack_q;
    assign load_err     = load_err_q;

endmodule

// File: tb/tb_tick_generator_param.sv
// Testbench for tick_generator_param (CNT_W=8, DEFAULT_DIV=5, SUB_DIV=3).
// Reference model tracks elapsed cycles in the current period, the number of
// ticks since the last restart and a one-deep queue of staged divisors.
module tb_tick_generator_param;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DEFAULT_DIV = 5;
    localparam int unsigned SUB_DIV     = 3;
    localparam int unsigned SUB_W       = 2;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             sync_clear;
    logic             div_load;
    logic [CNT_W-1:0] div_value;
    logic             load_ack;
    logic             load_err;
    logic             tick_out;
    logic             sub_tick_out;
    logic [CNT_W-1:0] count_out;
    logic             square_out;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_period;
    int m_phase;
    int m_ticks;
    int m_pend[$];
    int e_ack, e_err, e_tick, e_sub;

    tick_generator_param #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .SUB_DIV    (SUB_DIV),
        .SUB_W      (SUB_W)
    ) dut (
        .clock_in    (clk),
        .reset       (reset),
        .enable      (enable),
        .sync_clear  (sync_clear),
        .div_load    (div_load),
        .div_value   (div_value),
        .load_ack    (load_ack),
        .load_err    (load_err),
        .tick_out    (tick_out),
        .sub_tick_out(sub_tick_out),
        .count_out   (count_out),
        .square_out  (square_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_square();
`ifdef TICK_SQUARE_OUT_EN
        return m_ticks % 2;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_period = DEFAULT_DIV;
        m_phase  = 0;
        m_ticks  = 0;
        m_pend.delete();
        e_ack = 0; e_err = 0; e_tick = 0; e_sub = 0;
    endtask

    // One clock edge of intended behaviour, given the sampled inputs
    task automatic model_step(input bit en, input bit sc, input bit ld, input int val);
        e_ack = 0; e_err = 0; e_tick = 0; e_sub = 0;
        if (sc) begin
            if (ld && val >= 2) begin
                m_period = val;
                e_ack = 1;
            end else begin
                if (ld) e_err = 1;
                if (m_pend.size() != 0) begin
                    m_period = m_pend[0];
                    e_ack = 1;
                end
            end
            m_pend.delete();
            m_phase = 0;
            m_ticks = 0;
        end else begin
            if (en) begin
                if (m_phase == m_period - 1) begin
                    e_tick = 1;
                    m_ticks++;
                    e_sub = (m_ticks % SUB_DIV == 0) ? 1 : 0;
                    if (m_pend.size() != 0) begin
                        m_period = m_pend.pop_front();
                        e_ack = 1;
                    end
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
            end
            if (ld) begin
                if (val >= 2) begin
                    m_pend.delete();
                    m_pend.push_back(val);
                end else begin
                    e_err = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},    int'(count_out),    m_period - 1 - m_phase);
        check({tag, ".tick"},     int'(tick_out),     e_tick);
        check({tag, ".sub_tick"}, int'(sub_tick_out), e_sub);
        check({tag, ".ack"},      int'(load_ack),     e_ack);
        check({tag, ".err"},      int'(load_err),     e_err);
        check({tag, ".square"},   int'(square_out),   exp_square());
    endtask

    // Drive inputs, clock once, advance model, compare after the edge
    task automatic step(input bit en, input bit sc, input bit ld, input int val, input string tag);
        enable     = en;
        sync_clear = sc;
        div_load   = ld;
        div_value  = CNT_W'(val);
        @(posedge clk);
        model_step(en, sc, ld, val);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges and held across one edge
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; sync_clear = 1'b0; div_load = 1'b0; div_value = '0;
        #1;
        do_reset("por");

        // Free run: ticks on edges 5,10,15,20; sub tick with the 15th-edge tick
        for (int e = 1; e <= 20; e++) begin
            step(1, 0, 0, 0, "run");
            check("run.tick_edge", int'(tick_out), (e % 5 == 0) ? 1 : 0);
            check("run.sub_edge", int'(sub_tick_out), (e == 15) ? 1 : 0);
        end

        // Staged divisor of 8 loaded at edge 2 of a fresh period
        do_reset("rst1");
        for (int e = 1; e <= 21; e++) begin
            step(1, 0, e == 2, 8, "load8");
            check("load8.tick_edge", int'(tick_out), (e == 5 || e == 13 || e == 21) ? 1 : 0);
            if (e == 5) check("load8.ack_edge", int'(load_ack), 1);
        end

        // Rejected loads keep the period
        step(1, 0, 1, 1, "bad1");
        check("bad1.err", int'(load_err), 1);
        step(1, 0, 1, 0, "bad0");
        step(1, 0, 0, 0, "bad.after");
        check("bad.err_clear", int'(load_err), 0);

        // Freeze at count 2
        do_reset("rst2");
        step(1, 0, 0, 0, "pre"); step(1, 0, 0, 0, "pre");
        check("freeze.start", int'(count_out), 2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "freeze");
        check("freeze.hold", int'(count_out), 2);

        // sync_clear at count 1 with direct load of 6
        step(1, 0, 0, 0, "sc.pre");
        check("sc.at1", int'(count_out), 1);
        step(1, 1, 1, 6, "sc");
        check("sc.count5", int'(count_out), 5);
        check("sc.ack", int'(load_ack), 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, "sc.after");
        check("sc.tick6", int'(tick_out), 1);

        // Reset with a pending load discards it
        step(1, 0, 1, 9, "pend");
        do_reset("rst3");
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, "post_rst");

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit en, sc, ld;
            int val;
            en  = ($urandom_range(0, 99) < 85);
            sc  = ($urandom_range(0, 99) < 3);
            ld  = ($urandom_range(0, 99) < 10);
            val = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1))
                                              : int'($urandom_range(2, 12));
            if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
            else step(en, sc, ld, val, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
